// File: rtl/hear_freq_pkg.sv
// Shared command codes and tone-band classifier for hear_freq.
package hear_freq_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_NONE = 3'b000;
    localparam cmd_t CMD_500  = 3'b001;
    localparam cmd_t CMD_1K   = 3'b010;
    localparam cmd_t CMD_1K5  = 3'b100;

    function automatic cmd_t classify(
        input logic [31:0] n,
        input logic [31:0] f1_lo,
        input logic [31:0] f1_hi,
        input logic [31:0] f2_lo,
        input logic [31:0] f2_hi,
        input logic [31:0] f3_lo,
        input logic [31:0] f3_hi
    );
        cmd_t c;
        c = CMD_NONE;
        unique case (1'b1)
            (n >= f1_lo && n <= f1_hi): c = CMD_500;
            (n >= f2_lo && n <= f2_hi): c = CMD_1K;
            (n >= f3_lo && n <= f3_hi): c = CMD_1K5;
            default:                    c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mic_edge_sync.sv
// Two-flop synchroniser plus delay flop; rise pulses one cycle per
// synchronised rising edge of the mic comparator.
module mic_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= d_async;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign q_sync = s2;
    assign rise   = s2 & ~prev;

endmodule

// File: rtl/hear_freq.sv
// Windowed edge-count tone detector. Define HEAR_FREQ_CONFIRM_EN to
// require two matching windows before a new nonzero command is shown.
module hear_freq
    import hear_freq_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned F1_LO         = 40,
    parameter int unsigned F1_HI         = 60,
    parameter int unsigned F2_LO         = 90,
    parameter int unsigned F2_HI         = 110,
    parameter int unsigned F3_LO         = 140,
    parameter int unsigned F3_HI         = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       mic,
    output logic       led,
    output logic [2:0] command
);

    localparam int unsigned WIN_W =
        (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic             mic_sync;
    logic             mic_rise;
    logic             pulse;
    logic             last;
    cmd_t             result;

`ifdef HEAR_FREQ_CONFIRM_EN
    cmd_t             prev_res;
`endif

    mic_edge_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (mic),
        .q_sync  (mic_sync),
        .rise    (mic_rise)
    );

    // rise already implies the synchronised level is high
    assign pulse = mic_rise & mic_sync;
    assign last  = (win_cnt == WIN_LAST);

    // total includes a pulse landing on the terminal cycle
    always_comb begin
        edge_nxt = edge_cnt;
        if (pulse && edge_cnt != CNT_MAX) begin
            edge_nxt = edge_cnt + CNT_W'(1);
        end
        result = classify(32'(edge_nxt),
                          F1_LO, F1_HI,
                          F2_LO, F2_HI,
                          F3_LO, F3_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            command  <= CMD_NONE;
            led      <= 1'b0;
`ifdef HEAR_FREQ_CONFIRM_EN
            prev_res <= CMD_NONE;
`endif
        end else if (!enable) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            command  <= CMD_NONE;
            led      <= 1'b0;
`ifdef HEAR_FREQ_CONFIRM_EN
            prev_res <= CMD_NONE;
`endif
        end else if (last) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
`ifdef HEAR_FREQ_CONFIRM_EN
            prev_res <= result;
            if (result == CMD_NONE) begin
                command <= CMD_NONE;
                led     <= 1'b0;
            end else if (result == prev_res) begin
                command <= result;
                led     <= 1'b1;
            end
`else
            command  <= result;
            led      <= (result != CMD_NONE);
`endif
        end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            edge_cnt <= edge_nxt;
        end
    end

endmodule

// File: tb/tb_hear_freq.sv
// Randomised bench for hear_freq against a window/edge-count model,
// with fixed tone scenarios pinned by literal expectations.
module tb_hear_freq;

    localparam int W    = 1000;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       mic;
    logic       led;
    logic [2:0] command;

    int checks = 0;
    int errors = 0;
    int half   = 0;

    hear_freq #(
        .WINDOW_CYCLES (W),
        .CNT_W         (CW),
        .F1_LO         (15),
        .F1_HI         (25),
        .F2_LO         (35),
        .F2_HI         (45),
        .F3_LO         (55),
        .F3_HI         (65)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .mic     (mic),
        .led     (led),
        .command (command)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // square wave, half-period in clk cycles; 0 holds the level
    initial begin
        int ph;
        ph  = 0;
        mic = 1'b0;
        forever begin
            @(negedge clk);
            if (half != 0) begin
                if (ph >= half - 1) begin
                    mic = ~mic;
                    ph  = 0;
                end else begin
                    ph++;
                end
            end
        end
    end

    function automatic logic [2:0] ref_class(input int n);
        if (n >= 15 && n <= 25) return 3'b001;
        if (n >= 35 && n <= 45) return 3'b010;
        if (n >= 55 && n <= 65) return 3'b100;
        return 3'b000;
    endfunction

    // reference: pin samples become edges two cycles later, counted
    // per window of W enabled cycles, result shown at the window end
    logic [2:0] m_cmd  = 3'b000;
    logic [2:0] m_prev = 3'b000;
    logic       hist [0:2];
    int         m_pos  = 0;
    int         m_cnt  = 0;

    initial begin
        logic       r;
        logic [2:0] c;
        for (int i = 0; i < 3; i++) hist[i] = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) hist[i] = 1'b0;
                m_pos  = 0;
                m_cnt  = 0;
                m_cmd  = 3'b000;
                m_prev = 3'b000;
            end else begin
                r       = hist[1] & ~hist[2];
                hist[2] = hist[1];
                hist[1] = hist[0];
                hist[0] = mic;
                if (!enable) begin
                    m_pos  = 0;
                    m_cnt  = 0;
                    m_cmd  = 3'b000;
                    m_prev = 3'b000;
                end else begin
                    if (r && m_cnt < CMAX) m_cnt++;
                    m_pos++;
                    if (m_pos == W) begin
                        c = ref_class(m_cnt);
`ifdef HEAR_FREQ_CONFIRM_EN
                        if (c == 3'b000) m_cmd = 3'b000;
                        else if (c == m_prev) m_cmd = c;
                        m_prev = c;
`else
                        m_cmd = c;
`endif
                        m_pos = 0;
                        m_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (command !== m_cmd || led !== (m_cmd != 3'b000)) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t command=%b led=%b want %b/%b",
                         $time, command, led, m_cmd, m_cmd != 3'b000);
            end
        end
    end

    task automatic lit(input string nm, input logic [2:0] got,
                       input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, got, exp);
        end
    endtask

    task automatic lit_out(input string nm, input logic [2:0] exp);
        lit(nm, command, exp);
        lit({nm, "_led"}, {2'b00, led}, {2'b00, exp != 3'b000});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rst(input logic v);
        @(posedge clk);
        #2 rst_n = v;
    endtask

    int halves [13] = '{25, 24, 26, 12, 13, 8, 9, 0, 5, 1, 3, 18, 40};

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        half   = 3;
        wait_cyc(20);
        lit_out("reset", 3'b000);
        set_rst(1'b1);
        wait_cyc(W / 2);
        lit_out("first_window", 3'b000);

        half = 25;
        wait_cyc(3 * W);
        lit_out("tone_500", 3'b001);
        half = 12;
        wait_cyc(3 * W);
        lit_out("tone_1k", 3'b010);
        half = 8;
        wait_cyc(3 * W);
        lit_out("tone_1k5", 3'b100);
        half = 0;
        wait_cyc(3 * W);
        lit_out("static", 3'b000);
        half = 5;
        wait_cyc(3 * W);
        lit_out("too_fast", 3'b000);
        half = 1;
        wait_cyc(3 * W);
        lit_out("saturate", 3'b000);

        half = 25;
        wait_cyc(3 * W + W / 3);
        enable = 1'b0;
        wait_cyc(1);
        lit_out("disable", 3'b000);
        wait_cyc(50);
        enable = 1'b1;
`ifndef HEAR_FREQ_CONFIRM_EN
        wait_cyc(W - 1);
        lit_out("reenable_early", 3'b000);
        wait_cyc(1);
        lit_out("reenable_done", 3'b001);
`else
        wait_cyc(2 * W);
`endif

        for (int i = 0; i < 15; i++) begin
            half = halves[$urandom_range(0, 12)];
            wait_cyc($urandom_range(200, 1800));
            if ($urandom_range(0, 5) == 0) begin
                enable = 1'b0;
                wait_cyc($urandom_range(1, 200));
                enable = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) begin
                set_rst(1'b0);
                wait_cyc($urandom_range(1, 20));
                set_rst(1'b1);
            end
        end
        wait_cyc(2 * W);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
